// File: rtl/bcd_seg7_scanner.sv
// Scans a latched 3-digit BCD word onto a common-anode 7-segment display.
// Leading-zero blanking, dash for non-BCD nibbles, and a per-frame pulse.
//
// state | meaning
// DIG0  | ones digit slot (an=1110)
// DIG1  | tens digit slot (an=1101)
// DIG2  | hundreds digit slot (an=1011)
module bcd_seg7_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int PCNT_W = $clog2(REFRESH_DIV);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2} state_t;

  state_t            state, state_next;
  logic [11:0]       hold;
  logic [PCNT_W-1:0] pcnt;
  logic              tick;
  logic [3:0]        an_next;
  logic [6:0]        seg_next;
  logic              frame_done_next;
  logic [3:0]        nib;
  logic              blank;

  function automatic logic [6:0] seg_encode(input logic [3:0] n);
    case (n)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = 7'b0111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (load) begin
      hold <= bcd_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign tick = (pcnt == PCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIG0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        DIG0:    state_next = DIG1;
        DIG1:    state_next = DIG2;
        default: state_next = DIG0;
      endcase
    end
  end

  // Zero nibbles are the only ones ever blanked, so a dash is never hidden.
  always_comb begin
    an_next  = 4'b1110;
    nib      = hold[3:0];
    blank    = 1'b0;
    case (state)
      DIG1: begin
        an_next = 4'b1101;
        nib     = hold[7:4];
        blank   = blank_lz && (hold[11:8] == 4'd0) && (hold[7:4] == 4'd0);
      end
      DIG2: begin
        an_next = 4'b1011;
        nib     = hold[11:8];
        blank   = blank_lz && (hold[11:8] == 4'd0);
      end
      default: begin
        an_next = 4'b1110;
        nib     = hold[3:0];
        blank   = 1'b0;
      end
    endcase
    seg_next        = blank ? 7'b1111111 : seg_encode(nib);
    frame_done_next = tick && (state == DIG2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      frame_done <= frame_done_next;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// Self-checking bench for bcd_seg7_scanner with a short refresh period.
// A time-based model pushes expected {an,seg,frame_done} per cycle into a queue.
module tb_bcd_seg7_scanner;

  localparam int R     = 4;
  localparam int FRAME = 3 * R;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bcd_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_k = 0;
  logic [11:0] m_hold = '0;
  logic [11:0] sb[$];
  logic [11:0] got, exp_v;

  bcd_seg7_scanner #(.REFRESH_DIV(R)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ref_seg(input logic [11:0] h, input int d, input logic b);
    logic [3:0] n;
    n = h[4*d +: 4];
    if (b && ((d == 2 && h[11:8] == 4'd0) || (d == 1 && h[11:8] == 4'd0 && h[7:4] == 4'd0)))
      return 7'b1111111;
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Edge k after reset release shows the digit selected before it: ((k-1)/R)%3.
  task automatic drive_cycle();
    int d;
    logic [3:0] ea;
    m_k++;
    d  = ((m_k - 1) / R) % 3;
    ea = (d == 0) ? 4'b1110 : (d == 1) ? 4'b1101 : 4'b1011;
    sb.push_back({ea, ref_seg(m_hold, d, blank_lz), (m_k % FRAME == 0)});
    if (load) m_hold = bcd_in;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; bcd_in = 12'h999; blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({an, seg, frame_done, dp} !== {4'b1111, 7'b1111111, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_hold: got an=%b seg=%b fd=%b dp=%b want 1111 1111111 0 1", an, seg, frame_done, dp);
    end
    rst_n = 1'b1; load = 1'b0;
    m_k = 0; m_hold = '0; sb.delete();
    drive_cycle();
    got = {an, seg, frame_done}; exp_v = sb.pop_front();
    n_cmp++;
    if (got !== exp_v || got !== {4'b1110, 7'b1000000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_first: got %b want %b", got, exp_v);
    end
  endtask

  task automatic test_scan();
    int pulses = 0;
    blank_lz = 1'b0; bcd_in = 12'h255; load = 1'b1;
    drive_cycle();
    load = 1'b0;
    got = {an, seg, frame_done}; exp_v = sb.pop_front();
    n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL scan_load: got %b want %b", got, exp_v); end
    repeat (2 * FRAME) begin
      drive_cycle();
      got = {an, seg, frame_done}; exp_v = sb.pop_front();
      if (frame_done) pulses++;
      n_cmp++;
      if (got !== exp_v || dp !== 1'b1) begin
        n_err++;
        $display("FAIL scan k=%0d: got %b dp=%b want %b dp=1", m_k, got, dp, exp_v);
      end
    end
    n_cmp++;
    if (pulses != 2) begin n_err++; $display("FAIL scan_frames: got %0d pulses want 2", pulses); end
  endtask

  task automatic test_blanking();
    logic [11:0] vals[3] = '{12'h007, 12'h000, 12'h105};
    blank_lz = 1'b1;
    foreach (vals[v]) begin
      bcd_in = vals[v]; load = 1'b1;
      drive_cycle();
      load = 1'b0;
      void'(sb.pop_front());
      repeat (FRAME + 1) begin
        drive_cycle();
        got = {an, seg, frame_done}; exp_v = sb.pop_front();
        n_cmp++;
        if (got !== exp_v) begin
          n_err++;
          $display("FAIL blank %h k=%0d: got %b want %b", vals[v], m_k, got, exp_v);
        end
      end
    end
    bcd_in = 12'h007; load = 1'b1;
    drive_cycle();
    load = 1'b0;
    void'(sb.pop_front());
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == FRAME / 2) blank_lz = 1'b0;
      drive_cycle();
      got = {an, seg, frame_done}; exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL blank_toggle k=%0d: got %b want %b", m_k, got, exp_v); end
    end
  endtask

  task automatic test_invalid();
    blank_lz = 1'b1; bcd_in = 12'h0A3; load = 1'b1;
    drive_cycle();
    load = 1'b0;
    void'(sb.pop_front());
    repeat (FRAME + 1) begin
      drive_cycle();
      got = {an, seg, frame_done}; exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL invalid k=%0d: got %b want %b", m_k, got, exp_v); end
    end
  endtask

  task automatic test_load_on_tick();
    blank_lz = 1'b0;
    for (int i = 0; i < FRAME && ((m_k + 1) % FRAME != 2 * R); i++) begin
      drive_cycle();
      got = {an, seg, frame_done}; exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL align k=%0d: got %b want %b", m_k, got, exp_v); end
    end
    bcd_in = 12'h123; load = 1'b1;
    drive_cycle();
    load = 1'b0;
    got = {an, seg, frame_done}; exp_v = sb.pop_front();
    n_cmp++;
    if (got !== exp_v) begin n_err++; $display("FAIL tick_load k=%0d: got %b want %b", m_k, got, exp_v); end
    drive_cycle();
    got = {an, seg, frame_done}; exp_v = sb.pop_front();
    n_cmp++;
    if (got !== exp_v || an !== 4'b1011 || seg !== 7'b1111001) begin
      n_err++;
      $display("FAIL tick_dig2: got an=%b seg=%b want an=1011 seg=1111001 (model %b)", an, seg, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < FRAME && (m_k % FRAME != R + 1); i++) begin
      drive_cycle();
      void'(sb.pop_front());
    end
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({an, seg, frame_done, dp} !== {4'b1111, 7'b1111111, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid_async: got an=%b seg=%b fd=%b dp=%b want 1111 1111111 0 1", an, seg, frame_done, dp);
    end
    #1;
    rst_n = 1'b1;
    m_k = 0; m_hold = '0; sb.delete();
    for (int i = 0; i < FRAME + 2; i++) begin
      drive_cycle();
      got = {an, seg, frame_done}; exp_v = sb.pop_front();
      n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL reset_mid k=%0d: got %b want %b", m_k, got, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_invalid();
    test_load_on_tick();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
